// File: rtl/matrix_op_defs_pkg.sv
// matrix_op_defs_pkg: shared matrix storage constants, slot checks, shape/name word packing and writer states
package matrix_op_defs_pkg;
  localparam int MATRIX_BLOCK_SIZE = 256;
  localparam int MATRIX_ADDR_WIDTH = 12;
  localparam int MATRIX_DATA_WIDTH = 32;
  localparam int MATRIX_METADATA_WORDS = 4;
  localparam int MATRIX_NUM_SLOTS = 6;
  typedef struct packed {
    logic [7:0] rows;
    logic [7:0] cols;
  } shape_t;
  typedef enum logic [2:0] {IDLE, CHECK, WRITE_META, STREAM, DONE} writer_state_e;
  function automatic logic is_valid_operand_id(input logic [2:0] id);
    return int'(id) < MATRIX_NUM_SLOTS;
  endfunction
  function automatic logic is_data_capacity_ok(input logic [15:0] n);
    return int'(n) <= MATRIX_BLOCK_SIZE - MATRIX_METADATA_WORDS;
  endfunction
  function automatic logic [31:0] encode_shape_word(input logic [7:0] rows, input logic [7:0] cols);
    return {16'h0, rows, cols};
  endfunction
  function automatic shape_t decode_shape_word(input logic [31:0] w);
    return shape_t'(w[15:0]);
  endfunction
  // name byte 4k lands in the least significant byte of name word k
  function automatic logic [31:0] pack_name_word(input logic [7:0] b0, input logic [7:0] b1,
                                                 input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction
endpackage

// File: rtl/matrix_address_getter.sv
// matrix_address_getter: base storage address of a matrix slot
module matrix_address_getter
  import matrix_op_defs_pkg::*;
#(
  parameter int BLOCK_SIZE = MATRIX_BLOCK_SIZE,
  parameter int ADDR_WIDTH = MATRIX_ADDR_WIDTH
) (
  input  logic [2:0]            id_i,
  output logic [ADDR_WIDTH-1:0] base_o
);
  assign base_o = ADDR_WIDTH'(int'(id_i) * BLOCK_SIZE);
endmodule

// File: rtl/matrix_result_writer.sv
// matrix_result_writer: writes shape/name metadata then a streamed element payload into a matrix slot
module matrix_result_writer
  import matrix_op_defs_pkg::*;
#(
  parameter int BLOCK_SIZE = MATRIX_BLOCK_SIZE,
  parameter int ADDR_WIDTH = MATRIX_ADDR_WIDTH,
  parameter int DATA_WIDTH = MATRIX_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_request,
  output logic                  write_ready,
  input  logic [2:0]            matrix_id,
  input  logic [7:0]            actual_rows,
  input  logic [7:0]            actual_cols,
  input  logic [7:0]            matrix_name [0:7],
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  writer_ready,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy
);
  writer_state_e state_q, state_d;
  logic [2:0] id_q, id_d;
  logic [7:0] rows_q, rows_d, cols_q, cols_d, meta_q, meta_d;
  logic [7:0] name_q [0:7];
  logic [7:0] name_d [0:7];
  logic [15:0] total_q, total_d, elem_q, elem_d, prod;
  logic err_q, err_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, base;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, meta_word;
  matrix_address_getter #(.BLOCK_SIZE(BLOCK_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) u_addr (
    .id_i  (id_q),
    .base_o(base)
  );
  assign prod = 16'(rows_q) * 16'(cols_q);
  assign meta_word = meta_q == 8'd0 ? DATA_WIDTH'(encode_shape_word(rows_q, cols_q)) :
                     meta_q == 8'd1 ? DATA_WIDTH'(pack_name_word(name_q[0], name_q[1], name_q[2], name_q[3])) :
                     meta_q == 8'd2 ? DATA_WIDTH'(pack_name_word(name_q[4], name_q[5], name_q[6], name_q[7])) :
                     '0;
  assign write_ready = state_q == IDLE;
  assign writer_ready = state_q == STREAM;
  assign busy = state_q != IDLE;
  assign write_done = state_q == DONE;
  assign write_error = err_q;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    rows_d = rows_q;
    cols_d = cols_q;
    name_d = name_q;
    meta_d = meta_q;
    elem_d = elem_q;
    total_d = total_q;
    err_d = err_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (write_request) begin
        state_d = CHECK;
        id_d = matrix_id;
        rows_d = actual_rows;
        cols_d = actual_cols;
        name_d = matrix_name;
        meta_d = '0;
        elem_d = '0;
        err_d = 1'b0;
      end
      CHECK: begin
        total_d = prod;
        if (!is_valid_operand_id(id_q) || rows_q == 8'd0 || cols_q == 8'd0 || !is_data_capacity_ok(prod)) begin
          err_d = 1'b1;
          state_d = DONE;
        end else state_d = WRITE_META;
      end
      WRITE_META: begin
        we_d = 1'b1;
        addr_d = base + ADDR_WIDTH'(meta_q);
        wdata_d = meta_word;
        meta_d = meta_q + 8'd1;
        if (meta_q == 8'(MATRIX_METADATA_WORDS - 1)) state_d = STREAM;
      end
      STREAM: if (data_valid) begin
        we_d = 1'b1;
        addr_d = base + ADDR_WIDTH'(MATRIX_METADATA_WORDS) + ADDR_WIDTH'(elem_q);
        wdata_d = data_in;
        elem_d = elem_q + 16'd1;
        if (elem_q + 16'd1 == total_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q <= '0;
      rows_q <= '0;
      cols_q <= '0;
      name_q <= '{default: '0};
      meta_q <= '0;
      elem_q <= '0;
      total_q <= '0;
      err_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      rows_q <= rows_d;
      cols_q <= cols_d;
      name_q <= name_d;
      meta_q <= meta_d;
      elem_q <= elem_d;
      total_q <= total_d;
      err_q <= err_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_matrix_result_writer.sv
// tb_matrix_result_writer: randomized sessions checked against a storage-write reference model
module tb_matrix_result_writer;
  import matrix_op_defs_pkg::*;
  localparam int AW = MATRIX_ADDR_WIDTH;
  localparam int DW = MATRIX_DATA_WIDTH;
  localparam int BS = MATRIX_BLOCK_SIZE;
  localparam int MW = MATRIX_METADATA_WORDS;
  logic clk = 1'b0;
  logic rst, write_request, write_ready, data_valid, writer_ready, write_done, write_error, mem_we, busy;
  logic [2:0] matrix_id;
  logic [7:0] actual_rows, actual_cols;
  logic [7:0] matrix_name [0:7];
  logic [7:0] nm [0:7];
  logic [DW-1:0] data_in, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] cap_addr[$], exp_addr[$];
  logic [DW-1:0] cap_data[$], exp_data[$], elems[$];
  int done_cnt = 0;
  logic last_err = 1'b0;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  matrix_result_writer dut (
    .clk(clk), .rst(rst), .write_request(write_request), .write_ready(write_ready),
    .matrix_id(matrix_id), .actual_rows(actual_rows), .actual_cols(actual_cols),
    .matrix_name(matrix_name), .data_in(data_in), .data_valid(data_valid),
    .writer_ready(writer_ready), .write_done(write_done), .write_error(write_error),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy)
  );
  always @(negedge clk) begin
    if (mem_we) begin
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_wdata);
    end
    if (write_done) begin
      done_cnt++;
      last_err = write_error;
    end
  end
  task automatic build_expected(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c);
    int base = int'(id) * BS;
    exp_addr = {};
    exp_data = {};
    for (int m = 0; m < MW; m++) begin
      exp_addr.push_back(AW'(base + m));
      if (m == 0) exp_data.push_back(DW'({r, c}));
      else if (m <= 2) exp_data.push_back(DW'({nm[4*m-1], nm[4*m-2], nm[4*m-3], nm[4*m-4]}));
      else exp_data.push_back('0);
    end
    for (int i = 0; i < elems.size(); i++) begin
      exp_addr.push_back(AW'(base + MW + i));
      exp_data.push_back(elems[i]);
    end
  endtask
  task automatic fill(input int n);
    elems = {};
    for (int i = 0; i < n; i++) elems.push_back(DW'($urandom));
    for (int i = 0; i < 8; i++) nm[i] = 8'($urandom_range(32, 126));
  endtask
  task automatic request(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c);
    @(negedge clk);
    write_request = 1'b1;
    matrix_id = id;
    actual_rows = r;
    actual_cols = c;
    matrix_name = nm;
    @(negedge clk);
    write_request = 1'b0;
  endtask
  task automatic run_session(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                             input int period, input bit poke, output bit timed_out);
    int idx = 0;
    bit poked = 0;
    request(id, r, c);
    timed_out = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (write_done) begin
        timed_out = 0;
        break;
      end
      if (writer_ready && idx < elems.size() && (period == 0 ? $urandom_range(1) == 1 : cyc % period == 0)) begin
        data_valid = 1'b1;
        data_in = elems[idx];
        idx++;
      end else data_valid = 1'b0;
      write_request = 1'b0;
      if (poke && writer_ready && !poked) begin
        poked = 1;
        write_request = 1'b1;
        matrix_id = 3'd5;
        actual_rows = 8'd1;
        actual_cols = 8'd1;
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
    write_request = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({write_ready, writer_ready, busy, mem_we, write_done, write_error} !== 6'b100000) begin
      mismatched++;
      $display("FAIL reset_flags: got %b expected 100000", {write_ready, writer_ready, busy, mem_we, write_done, write_error});
    end
    compared++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      mismatched++;
      $display("FAIL reset_mem: got addr %0h data %0h expected 0 0", mem_addr, mem_wdata);
    end
  endtask
  task automatic test_scalres();
    int a0 = cap_addr.size(), d0 = done_cnt;
    bit to;
    nm = '{8'h53, 8'h43, 8'h41, 8'h4C, 8'h52, 8'h45, 8'h53, 8'h00};
    elems = {};
    for (int i = 1; i <= 6; i++) elems.push_back(DW'(i));
    build_expected(3'd0, 8'd2, 8'd3);
    run_session(3'd0, 8'd2, 8'd3, 3, 0, to);
    repeat (3) @(negedge clk);
    compared++;
    if (to) begin
      mismatched++;
      $display("FAIL scalres_timeout: got no write_done expected write_done");
    end
    compared++;
    if (cap_addr.size() - a0 != MW + 6 || done_cnt - d0 != 1 || last_err !== 1'b0) begin
      mismatched++;
      $display("FAIL scalres_counts: got writes %0d dones %0d err %b expected %0d 1 0", cap_addr.size() - a0, done_cnt - d0, last_err, MW + 6);
    end else begin
      compared++;
      if (cap_data[a0+1] !== 32'h4C414353 || cap_data[a0+2] !== 32'h00534552 || cap_data[a0] !== 32'h00000203) begin
        mismatched++;
        $display("FAIL scalres_meta: got %0h %0h %0h expected 203 4c414353 534552", cap_data[a0], cap_data[a0+1], cap_data[a0+2]);
      end
      for (int i = 0; i < MW + 6; i++) begin
        compared++;
        if (cap_addr[a0+i] !== exp_addr[i] || cap_data[a0+i] !== exp_data[i]) begin
          mismatched++;
          $display("FAIL scalres_word%0d: got %0h:%0h expected %0h:%0h", i, cap_addr[a0+i], cap_data[a0+i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask
  task automatic test_single();
    int a0 = cap_addr.size(), d0 = done_cnt;
    logic [2:0] id = 3'($urandom_range(0, MATRIX_NUM_SLOTS - 1));
    bit to;
    fill(0);
    elems.push_back('1);
    build_expected(id, 8'd1, 8'd1);
    run_session(id, 8'd1, 8'd1, 1, 0, to);
    repeat (3) @(negedge clk);
    compared++;
    if (to || cap_addr.size() - a0 != MW + 1 || done_cnt - d0 != 1) begin
      mismatched++;
      $display("FAIL single_counts: got writes %0d dones %0d timeout %b expected %0d 1 0", cap_addr.size() - a0, done_cnt - d0, to, MW + 1);
    end else begin
      compared++;
      if (cap_addr[a0+MW] !== exp_addr[MW] || cap_data[a0+MW] !== 32'hFFFFFFFF) begin
        mismatched++;
        $display("FAIL single_data: got %0h:%0h expected %0h:ffffffff", cap_addr[a0+MW], cap_data[a0+MW], exp_addr[MW]);
      end
    end
  endtask
  task automatic test_errors();
    logic [2:0] ids [4] = '{3'd1, 3'd2, 3'd6, 3'd7};
    logic [7:0] rs [4] = '{8'd0, 8'd3, 8'd2, 8'd1};
    logic [7:0] cs [4] = '{8'd4, 8'd0, 8'd2, 8'd253};
    for (int t = 0; t < 4; t++) begin
      int a0 = cap_addr.size();
      bit seen = 0, err = 0;
      if (t == 3) ids[t] = 3'($urandom_range(0, MATRIX_NUM_SLOTS - 1));
      fill(0);
      request(ids[t], rs[t], cs[t]);
      for (int k = 0; k < 3 && !seen; k++) begin
        if (write_done) begin
          seen = 1;
          err = write_error;
        end else @(negedge clk);
      end
      repeat (3) @(negedge clk);
      compared++;
      if (!seen || err !== 1'b1 || cap_addr.size() != a0) begin
        mismatched++;
        $display("FAIL error_case%0d: got done %b err %b writes %0d expected 1 1 0", t, seen, err, cap_addr.size() - a0);
      end
    end
  endtask
  task automatic test_ignore_request();
    int a0 = cap_addr.size(), d0 = done_cnt;
    bit to;
    fill(4);
    build_expected(3'd2, 8'd2, 8'd2);
    run_session(3'd2, 8'd2, 8'd2, 2, 1, to);
    repeat (8) @(negedge clk);
    compared++;
    if (to || cap_addr.size() - a0 != MW + 4 || done_cnt - d0 != 1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL ignore_counts: got writes %0d dones %0d busy %b expected %0d 1 0", cap_addr.size() - a0, done_cnt - d0, busy, MW + 4);
    end else
      for (int i = 0; i < MW + 4; i++) begin
        compared++;
        if (cap_addr[a0+i] !== exp_addr[i] || cap_data[a0+i] !== exp_data[i]) begin
          mismatched++;
          $display("FAIL ignore_word%0d: got %0h:%0h expected %0h:%0h", i, cap_addr[a0+i], cap_data[a0+i], exp_addr[i], exp_data[i]);
        end
      end
  endtask
  task automatic test_reset_mid();
    int a0 = cap_addr.size(), d0 = done_cnt, fed = 0;
    bit to;
    fill(4);
    request(3'd3, 8'd2, 8'd2);
    for (int k = 0; k < 40 && fed < 2; k++) begin
      if (writer_ready) begin
        data_valid = 1'b1;
        data_in = elems[fed];
        fed++;
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared++;
    if (mem_we !== 1'b0 || write_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_state: got mem_we %b write_ready %b expected 0 1", mem_we, write_ready);
    end
    repeat (5) @(negedge clk);
    compared++;
    if (done_cnt != d0 || cap_addr.size() - a0 != MW + 2) begin
      mismatched++;
      $display("FAIL rstmid_abort: got dones %0d writes %0d expected 0 %0d", done_cnt - d0, cap_addr.size() - a0, MW + 2);
    end
    a0 = cap_addr.size();
    fill(1);
    build_expected(3'd4, 8'd1, 8'd1);
    run_session(3'd4, 8'd1, 8'd1, 1, 0, to);
    repeat (3) @(negedge clk);
    compared++;
    if (to || cap_addr.size() - a0 != MW + 1 || last_err !== 1'b0 || cap_data[a0+MW] !== exp_data[MW]) begin
      mismatched++;
      $display("FAIL rstmid_fresh: got writes %0d timeout %b err %b expected %0d 0 0", cap_addr.size() - a0, to, last_err, MW + 1);
    end
  endtask
  task automatic test_hold_valid();
    int a0 = cap_addr.size(), d0 = done_cnt;
    fill(10);
    build_expected(3'd1, 8'd2, 8'd2);
    for (int i = 0; i < 6; i++) void'(exp_addr.pop_back());
    for (int i = 0; i < 6; i++) void'(exp_data.pop_back());
    request(3'd1, 8'd2, 8'd2);
    for (int k = 0; k < 20 && !writer_ready; k++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      data_valid = 1'b1;
      data_in = elems[k];
      @(negedge clk);
    end
    data_valid = 1'b0;
    compared++;
    if (writer_ready !== 1'b0 || cap_addr.size() - a0 != MW + 4 || done_cnt - d0 != 1) begin
      mismatched++;
      $display("FAIL hold_counts: got ready %b writes %0d dones %0d expected 0 %0d 1", writer_ready, cap_addr.size() - a0, done_cnt - d0, MW + 4);
    end else
      for (int i = 0; i < MW + 4; i++) begin
        compared++;
        if (cap_addr[a0+i] !== exp_addr[i] || cap_data[a0+i] !== exp_data[i]) begin
          mismatched++;
          $display("FAIL hold_word%0d: got %0h:%0h expected %0h:%0h", i, cap_addr[a0+i], cap_data[a0+i], exp_addr[i], exp_data[i]);
        end
      end
  endtask
  task automatic test_random();
    for (int s = 0; s < 7; s++) begin
      int a0 = cap_addr.size(), d0 = done_cnt;
      logic [2:0] id = 3'($urandom_range(0, MATRIX_NUM_SLOTS - 1));
      logic [7:0] r = s == 0 ? 8'd12 : 8'($urandom_range(1, 12));
      logic [7:0] c = s == 0 ? 8'd21 : 8'($urandom_range(1, 12));
      bit to;
      fill(int'(r) * int'(c));
      build_expected(id, r, c);
      run_session(id, r, c, 0, 0, to);
      repeat (3) @(negedge clk);
      compared++;
      if (to || cap_addr.size() - a0 != exp_addr.size() || done_cnt - d0 != 1 || last_err !== 1'b0) begin
        mismatched++;
        $display("FAIL random%0d_counts: got writes %0d dones %0d err %b expected %0d 1 0", s, cap_addr.size() - a0, done_cnt - d0, last_err, exp_addr.size());
      end else
        for (int i = 0; i < exp_addr.size(); i++) begin
          compared++;
          if (cap_addr[a0+i] !== exp_addr[i] || cap_data[a0+i] !== exp_data[i]) begin
            mismatched++;
            $display("FAIL random%0d_word%0d: got %0h:%0h expected %0h:%0h", s, i, cap_addr[a0+i], cap_data[a0+i], exp_addr[i], exp_data[i]);
          end
        end
    end
  endtask
  initial begin
    rst = 1'b1;
    write_request = 1'b0;
    data_valid = 1'b0;
    data_in = '0;
    matrix_id = '0;
    actual_rows = '0;
    actual_cols = '0;
    matrix_name = '{default: '0};
    nm = '{default: '0};
    test_reset();
    test_scalres();
    test_single();
    test_errors();
    test_ignore_request();
    test_reset_mid();
    test_hold_valid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
